lvds_frame_process: RTL and testbench
=====================================

LVDS_FRAME_PROCESS -- requirements
Module: lvds_frame_process

Interface
REQ-001 SHALL have parameter DW, default 32, width of one channel sample.
REQ-002 SHALL have parameter CH, default 2, number of channels per input beat (1..8).
REQ-003 SHALL have parameter FRAME_LEN, default 8000, number of beats per frame (2..65535).
REQ-004 SHALL have parameter DEPTH, default 128, beat-FIFO depth (power of 2, at least 4).
REQ-005 SHALL use one clock and an asynchronous, active-high reset: clk_ps and rst.
REQ-006 SHALL have port clk_ps, input, 1 bit: the only clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-008 SHALL have port select, input, 1 bit: 1 selects test-pattern mode, 0 selects live data.
REQ-009 SHALL have port pattern_sel, input, 1 bit: 0 selects ramp, 1 selects inverted ramp.
REQ-010 SHALL have port lvds_data_en, input, 1 bit: input beat valid; there is no back-pressure.
REQ-011 SHALL have port lvds_data, input, CH*DW bits: channel c occupies bits [c*DW +: DW].
REQ-012 SHALL have port data_out_ready, input, 1 bit: downstream accepts a word.
REQ-013 SHALL have port data_out_en, output, 1 bit: output word valid.
REQ-014 SHALL have port data_out, output, DW bits: serialised channel word.
REQ-015 SHALL have port data_out_sof, output, 1 bit: flags channel 0 of beat 0 of a frame.
REQ-016 SHALL have port data_out_eof, output, 1 bit: flags channel CH-1 of beat FRAME_LEN-1.
REQ-017 SHALL have port overflow, output, 1 bit: sticky flag set when a beat is dropped.
REQ-018 SHALL have port ovf_clr, input, 1 bit: clears overflow.

Function
REQ-019 SHALL count input beats in beat_idx, range 0..FRAME_LEN-1, incrementing on each lvds_data_en and wrapping to 0 after FRAME_LEN-1.
REQ-020 SHALL implement the mode FSM as follows:
- LIVE: on a select rising edge -> ARM.
- ARM: on an accepted beat with beat_idx==FRAME_LEN-1 -> TEST.
- TEST: on a select falling edge -> DISARM.
- DISARM: on an accepted beat with beat_idx==FRAME_LEN-1 -> LIVE.
REQ-021 SHALL detect the select edges using select registered once (select_d).
REQ-022 SHALL, in DISARM, ignore a new select rising edge; if select is 1 on DISARM exit, the FSM passes through LIVE and detects the next rising edge normally.
REQ-023 SHALL switch the data source only at frame boundaries:
- states LIVE and ARM store lvds_data;
- states TEST and DISARM store the test pattern.
REQ-024 SHALL compute test word for channel c as (beat_idx + c) modulo 2^DW, bitwise-inverted when pattern_sel=1.
REQ-025 SHALL sample pattern_sel only on beat 0 and hold it for the rest of the frame.
REQ-026 SHALL register each accepted beat together with its sof/eof tags and write it to the FIFO one cycle after lvds_data_en.
REQ-027 SHALL, when the FIFO is full at write time, drop the whole beat, set overflow, and leave beat_idx advancing.
REQ-028 SHALL make ovf_clr take priority over a simultaneous overflow set.
REQ-029 SHALL serialise each FIFO beat as CH output words, channel 0 first.
REQ-030 SHALL advance to the next word only when data_out_en and data_out_ready are both 1.
REQ-031 SHALL hold data_out, data_out_sof and data_out_eof stable while data_out_en=1 and data_out_ready=0.
REQ-032 SHALL produce the first word on data_out_en at the earliest 2 cycles after the beat's lvds_data_en (one cycle input register, one cycle FIFO/output register).
REQ-033 SHALL sustain one output word per cycle under continuous ready, with no bubble between beats.
REQ-034 SHALL correctly handle a FIFO read and write in the same cycle, including at full and at empty.

Reset
REQ-035 SHALL, during rst, set all of the following:
- FSM state = LIVE;
- beat_idx = 0;
- FIFO empty;
- serialiser channel = 0;
- data_out_en, data_out_sof, data_out_eof and overflow = 0;
- data_out = 0.
REQ-036 SHALL, when rst is asserted mid-frame, discard all buffered beats; the first beat after release is beat 0 with sof.

Verification
REQ-037 SHALL cover, with CH=2 and FRAME_LEN=8: live beats {A1,A0} with ready=1 -> data_out A0 then A1; sof on A0 of beat 0; eof on beat 7 channel 1.
REQ-038 SHALL cover select rising at beat 3 -> beats 3-7 live; next frame data_out 0,1,1,2,...,7,8; state TEST.
REQ-039 SHALL cover select falling mid test frame -> pattern continues to beat 7, then live data from beat 0.
REQ-040 SHALL cover pattern_sel=1 in TEST, DW=32 -> beat 0 channel 0 = 0xFFFFFFFF, channel 1 = 0xFFFFFFFE.
REQ-041 SHALL cover ready=0 with DEPTH=4 and continuous beats -> exactly 4 beats retained, overflow=1; ovf_clr with simultaneous drop -> overflow=0.
REQ-042 SHALL cover rst pulsed while 3 beats are queued -> data_out_en=0 next cycle; subsequent output starts with sof at beat 0.

Source files
------------

// File: rtl/lvds_frame_process.sv
// LVDS beat framer: tags frames, optionally swaps live data for a ramp test pattern
// at frame boundaries, buffers beats in a FIFO and serialises them one channel per word.
//
// state  | meaning
// LIVE   | live data stored; waiting for select rising edge
// ARM    | still live; switches to pattern after the current frame ends
// TEST   | pattern stored; waiting for select falling edge
// DISARM | still pattern; returns to live after the current frame ends
module lvds_frame_process #(
    parameter int DW        = 32,
    parameter int CH        = 2,
    parameter int FRAME_LEN = 8000,
    parameter int DEPTH     = 128
) (
    input  logic              clk_ps,
    input  logic              rst,
    input  logic              select,
    input  logic              pattern_sel,
    input  logic              lvds_data_en,
    input  logic [CH*DW-1:0]  lvds_data,
    input  logic              data_out_ready,
    output logic              data_out_en,
    output logic [DW-1:0]     data_out,
    output logic              data_out_sof,
    output logic              data_out_eof,
    output logic              overflow,
    input  logic              ovf_clr
);

    localparam int BW = $clog2(FRAME_LEN);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (CH > 1) ? $clog2(CH) : 1;
    localparam int FW = CH*DW + 2;
    localparam logic [BW-1:0] LAST_BEAT = BW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] LAST_CH   = CW'(CH - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {LIVE, ARM, TEST, DISARM} state_t;

    state_t            r_state;
    logic              r_select_d;
    logic [BW-1:0]     r_beat_idx;
    logic              r_pat_inv;

    logic              r_in_vld;
    logic [CH*DW-1:0]  r_in_data;
    logic              r_in_sof;
    logic              r_in_eof;

    logic [FW-1:0]     r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic [CW-1:0]     r_ch;
    logic              r_overflow;

    logic              w_sel_rise;
    logic              w_sel_fall;
    logic              w_last_beat;
    logic              w_pat_inv;
    logic              w_use_pattern;
    logic [CH*DW-1:0]  w_pattern;
    logic              w_full;
    logic              w_empty;
    logic [FW-1:0]     w_head;
    logic [CH*DW-1:0]  w_head_data;
    logic              w_word_take;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;

    assign w_sel_rise    = select & ~r_select_d;
    assign w_sel_fall    = ~select & r_select_d;
    assign w_last_beat   = lvds_data_en && (r_beat_idx == LAST_BEAT);
    assign w_use_pattern = (r_state == TEST) || (r_state == DISARM);

    // Beat 0 uses pattern_sel directly; later beats reuse the value latched on beat 0.
    assign w_pat_inv = (r_beat_idx == '0) ? pattern_sel : r_pat_inv;

    always_comb begin
        w_pattern = '0;
        for (int c = 0; c < CH; c++) begin
            w_pattern[c*DW +: DW] = (DW'(r_beat_idx) + DW'(c)) ^ {DW{w_pat_inv}};
        end
    end

    always_ff @(posedge clk_ps or posedge rst) begin
        if (rst) begin
            r_state    <= LIVE;
            r_select_d <= 1'b0;
        end else begin
            r_select_d <= select;
            case (r_state)
                LIVE:    if (w_sel_rise)  r_state <= ARM;
                ARM:     if (w_last_beat) r_state <= TEST;
                TEST:    if (w_sel_fall)  r_state <= DISARM;
                DISARM:  if (w_last_beat) r_state <= LIVE;
                default:                  r_state <= LIVE;
            endcase
        end
    end

    always_ff @(posedge clk_ps or posedge rst) begin
        if (rst) begin
            r_beat_idx <= '0;
            r_pat_inv  <= 1'b0;
            r_in_vld   <= 1'b0;
            r_in_data  <= '0;
            r_in_sof   <= 1'b0;
            r_in_eof   <= 1'b0;
        end else begin
            r_in_vld <= lvds_data_en;
            if (lvds_data_en) begin
                r_in_data  <= w_use_pattern ? w_pattern : lvds_data;
                r_in_sof   <= (r_beat_idx == '0);
                r_in_eof   <= (r_beat_idx == LAST_BEAT);
                r_beat_idx <= (r_beat_idx == LAST_BEAT) ? '0 : r_beat_idx + 1'b1;
                if (r_beat_idx == '0) begin
                    r_pat_inv <= pattern_sel;
                end
            end
        end
    end

    assign w_full      = (r_count == FULL_CNT);
    assign w_empty     = (r_count == '0);
    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_data = w_head[FW-1:2];
    assign w_word_take = data_out_en && data_out_ready;
    assign w_pop       = w_word_take && (r_ch == LAST_CH);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept the beat.
    assign w_push      = r_in_vld && (!w_full || w_pop);
    assign w_drop      = r_in_vld && w_full && !w_pop;

    always_ff @(posedge clk_ps) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {r_in_data, r_in_sof, r_in_eof};
        end
    end

    always_ff @(posedge clk_ps or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ch       <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_word_take) begin
                r_ch <= (r_ch == LAST_CH) ? '0 : r_ch + 1'b1;
            end
            if (ovf_clr) begin
                r_overflow <= 1'b0;
            end else if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Output presents the FIFO head directly, so the FIFO depth is the full retention.
    assign data_out_en  = !w_empty;
    assign data_out     = data_out_en ? w_head_data[int'(r_ch)*DW +: DW] : '0;
    assign data_out_sof = data_out_en && w_head[1] && (r_ch == '0);
    assign data_out_eof = data_out_en && w_head[0] && (r_ch == LAST_CH);
    assign overflow     = r_overflow;

endmodule

// File: tb/tb_lvds_frame_process.sv
// Scoreboard bench for lvds_frame_process with CH=2, FRAME_LEN=8, DEPTH=4, DW=32.
module tb_lvds_frame_process;

    logic        clk_ps = 1'b0;
    logic        rst;
    logic        select;
    logic        pattern_sel;
    logic        lvds_data_en;
    logic [63:0] lvds_data;
    logic        data_out_ready;
    logic        data_out_en;
    logic [31:0] data_out;
    logic        data_out_sof;
    logic        data_out_eof;
    logic        overflow;
    logic        ovf_clr;

    always #5 clk_ps = ~clk_ps;

    lvds_frame_process #(.DW(32), .CH(2), .FRAME_LEN(8), .DEPTH(4)) dut (
        .clk_ps         (clk_ps),
        .rst            (rst),
        .select         (select),
        .pattern_sel    (pattern_sel),
        .lvds_data_en   (lvds_data_en),
        .lvds_data      (lvds_data),
        .data_out_ready (data_out_ready),
        .data_out_en    (data_out_en),
        .data_out       (data_out),
        .data_out_sof   (data_out_sof),
        .data_out_eof   (data_out_eof),
        .overflow       (overflow),
        .ovf_clr        (ovf_clr)
    );

    typedef struct packed {
        logic [31:0] d;
        logic        sof;
        logic        eof;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   tb_beat = 0;
    int   g = 0;

    function automatic logic [31:0] lv0(input int n);
        return 32'hA000_0000 + 32'(n);
    endfunction

    function automatic logic [31:0] lv1(input int n);
        return 32'hB000_0000 + 32'(n);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one beat; optionally queue its expected words; then idle for gap cycles.
    task automatic send(input logic [31:0] l0, input logic [31:0] l1,
                        input logic [31:0] e0, input logic [31:0] e1,
                        input bit keep, input int gap);
        lvds_data    = {l1, l0};
        lvds_data_en = 1'b1;
        if (keep) begin
            exp_q.push_back('{d: e0, sof: (tb_beat == 0), eof: 1'b0});
            exp_q.push_back('{d: e1, sof: 1'b0, eof: (tb_beat == 7)});
        end
        tb_beat = (tb_beat == 7) ? 0 : tb_beat + 1;
        g++;
        @(posedge clk_ps); #1;
        lvds_data_en = 1'b0;
        for (int i = 0; i < gap; i++) begin
            @(posedge clk_ps); #1;
        end
    endtask

    task automatic live_beat(input bit keep, input int gap);
        send(lv0(g), lv1(g), lv0(g), lv1(g), keep, gap);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_ps); #1;
        end
    endtask

    always @(negedge clk_ps) begin
        if (!rst && data_out_en && data_out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL mon_unexpected: got %h sof=%b eof=%b expected no word",
                         data_out, data_out_sof, data_out_eof);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("mon_word", {30'd0, data_out, data_out_sof, data_out_eof},
                    {30'd0, e.d, e.sof, e.eof});
            end
        end
    end

    logic [31:0] stall_word;

    initial begin
        rst = 1'b1; select = 1'b0; pattern_sel = 1'b0; lvds_data_en = 1'b0;
        lvds_data = '0; data_out_ready = 1'b1; ovf_clr = 1'b0;
        idle(3);
        chk("rst_en",  data_out_en,  0);
        chk("rst_data", data_out,    0);
        chk("rst_sof", data_out_sof, 0);
        chk("rst_eof", data_out_eof, 0);
        chk("rst_ovf", overflow,     0);
        rst = 1'b0;
        idle(1);

        // Frame 0: live, with latency check on the first beat
        lvds_data    = {lv1(g), lv0(g)};
        lvds_data_en = 1'b1;
        exp_q.push_back('{d: lv0(g), sof: 1'b1, eof: 1'b0});
        exp_q.push_back('{d: lv1(g), sof: 1'b0, eof: 1'b0});
        tb_beat = 1; g++;
        @(posedge clk_ps); #1;
        lvds_data_en = 1'b0;
        chk("lat_1cyc_en", data_out_en, 0);
        @(posedge clk_ps); #1;
        chk("lat_2cyc_en", data_out_en, 1);
        chk("lat_2cyc_word", data_out, lv0(0));
        for (int k = 1; k < 8; k++) live_beat(1, 1);

        // Frame 1: select rises at beat 3, whole frame stays live
        for (int k = 0; k < 8; k++) begin
            if (k == 3) select = 1'b1;
            live_beat(1, 1);
        end

        // Frame 2: ramp pattern
        pattern_sel = 1'b0;
        for (int k = 0; k < 8; k++) begin
            send(lv0(g), lv1(g), 32'(k), 32'(k + 1), 1, 1);
        end

        // Frame 3: inverted ramp; select falls at beat 3, pattern_sel changes at 4,
        // select rises again at 5 (ignored while disarming)
        pattern_sel = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k == 3) select = 1'b0;
            if (k == 4) pattern_sel = 1'b0;
            if (k == 5) select = 1'b1;
            send(lv0(g), lv1(g), ~32'(k), ~32'(k + 1), 1, 1);
        end

        // Frame 4: live from beat 0; falling select in LIVE changes nothing
        for (int k = 0; k < 8; k++) begin
            if (k == 6) select = 1'b0;
            live_beat(1, 1);
        end
        idle(4);

        // Frame 5: stalled output, continuous beats, two dropped
        data_out_ready = 1'b0;
        stall_word = lv0(g);
        for (int k = 0; k < 6; k++) live_beat(k < 4, 0);
        idle(2);
        chk("stall_en",   data_out_en,  1);
        chk("stall_word", data_out,     stall_word);
        chk("stall_sof",  data_out_sof, 1);
        chk("ovf_set",    overflow,     1);
        idle(3);
        chk("stall_hold", data_out, stall_word);
        chk("stall_hold_sof", data_out_sof, 1);
        live_beat(0, 0);
        ovf_clr = 1'b1;
        @(posedge clk_ps); #1;
        ovf_clr = 1'b0;
        chk("ovf_clr_prio", overflow, 0);
        data_out_ready = 1'b1;
        idle(10);
        chk("ovf_stays_clr", overflow, 0);
        live_beat(1, 1);
        idle(4);

        // Frame 6: reset with three beats queued
        data_out_ready = 1'b0;
        for (int k = 0; k < 3; k++) live_beat(1, 0);
        idle(2);
        chk("queued_en", data_out_en, 1);
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("rst_async_en", data_out_en, 0);
        @(posedge clk_ps); #1;
        chk("rst_next_en", data_out_en, 0);
        rst = 1'b0;
        tb_beat = 0;
        data_out_ready = 1'b1;
        for (int k = 0; k < 3; k++) live_beat(1, 1);

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk_ps);
        chk("drain_empty", 64'(exp_q.size()), 0);
        idle(4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
